mdio_master: RTL and testbench

Clause-22 MDIO management master: issues one read or write frame to an external PHY per start request and generates MDC from sys_clk. It sits between the debounced key-flag/control logic (the request side) and the PHY management pins (the initiator side of the MDIO bus). A single start pulse produces one complete 64-bit frame, a done pulse, and read data plus a turnaround-error flag.

---
 rtl/mdio_master_pkg.sv | 29 ++
 rtl/mdio_master_mdc_gen.sv | 38 +++
 rtl/mdio_master.sv | 123 ++++++++++++
 tb/tb_mdio_master.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mdio_master_pkg.sv
// Shared MDIO Clause-22 frame constants, FSM state type and transmit-word builder.
package mdio_master_pkg;

  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;

  localparam int unsigned MDIO_PRE_LEN   = 32;
  localparam int unsigned MDIO_FRAME_LEN = 64;
  localparam int unsigned MDIO_TA_BIT    = 47;
  localparam int unsigned MDIO_CMD_LAST  = 45;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_CMD,
    ST_TA,
    ST_DATA
  } mdio_state_t;

  // ST..DATA portion of the frame; TA/DATA are don't-care on reads (bus released)
  function automatic logic [31:0] mdio_tx_word(input logic        rd,
                                               input logic [4:0]  pa,
                                               input logic [4:0]  ra,
                                               input logic [15:0] wd);
    return {MDIO_ST, (rd ? MDIO_OP_RD : MDIO_OP_WR), pa, ra, 2'b10, wd};
  endfunction

endpackage

// File: rtl/mdio_master_mdc_gen.sv
// MDC generator: divides sys_clk by 2*CLK_DIV while enabled, idles low otherwise.
module mdc_gen #(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_enable,
  output logic o_mdc,
  output logic o_mdc_rise,
  output logic o_mdc_fall
);

  localparam int unsigned     CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_mdc;
  logic             w_term;

  // Strobes mark the sys_clk edge on which mdc toggles, so callers update in lockstep
  assign w_term     = i_enable && (r_cnt == CNT_LAST);
  assign o_mdc_rise = w_term && !r_mdc;
  assign o_mdc_fall = w_term && r_mdc;
  assign o_mdc      = r_mdc;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || !i_enable) begin
      r_cnt <= '0;
      r_mdc <= 1'b0;
    end else if (w_term) begin
      r_cnt <= '0;
      r_mdc <= ~r_mdc;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: one 64-bit read or write frame per accepted start pulse.
module mdio_master
  import mdio_master_pkg::*;
#(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic        op_rd,
  input  logic [4:0]  phy_addr,
  input  logic [4:0]  reg_addr,
  input  logic [15:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        rd_err,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  mdio_state_t r_state, w_next;

  logic [5:0]  r_bit_cnt;
  logic [31:0] r_tx_sr;
  logic [15:0] r_rx_sr;
  logic [15:0] r_rd_data;
  logic        r_op_rd, r_ta_err, r_rd_err, r_done;
  logic        w_busy, w_start_acc, w_rise, w_fall, w_last_bit;
  logic        w_oe, w_tx_bit;

  assign w_busy      = (r_state != ST_IDLE);
  assign w_start_acc = start && !w_busy;
  assign w_last_bit  = w_fall && (r_bit_cnt == 6'(MDIO_FRAME_LEN - 1));

  mdc_gen #(.CLK_DIV(CLK_DIV)) u_mdc_gen (
    .i_clk      (sys_clk),
    .i_rst_n    (sys_rst_n),
    .i_enable   (w_busy),
    .o_mdc      (mdc),
    .o_mdc_rise (w_rise),
    .o_mdc_fall (w_fall)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) r_state <= ST_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start_acc) w_next = ST_PRE;
      ST_PRE:  if (w_fall && r_bit_cnt == 6'(MDIO_PRE_LEN - 1)) w_next = ST_CMD;
      ST_CMD:  if (w_fall && r_bit_cnt == 6'(MDIO_CMD_LAST))    w_next = ST_TA;
      ST_TA:   if (w_fall && r_bit_cnt == 6'(MDIO_TA_BIT))      w_next = ST_DATA;
      ST_DATA: if (w_last_bit)                                  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Reads release the bus from the first TA bit onward
  always_comb begin
    w_oe     = 1'b0;
    w_tx_bit = 1'b1;
    case (r_state)
      ST_PRE: w_oe = 1'b1;
      ST_CMD: begin
        w_oe     = 1'b1;
        w_tx_bit = r_tx_sr[31];
      end
      ST_TA, ST_DATA: begin
        w_oe     = !r_op_rd;
        w_tx_bit = r_tx_sr[31];
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_bit_cnt <= '0;
      r_tx_sr   <= '0;
      r_rx_sr   <= '0;
      r_rd_data <= '0;
      r_op_rd   <= 1'b0;
      r_ta_err  <= 1'b0;
      r_rd_err  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_last_bit;
      if (w_start_acc) begin
        r_tx_sr   <= mdio_tx_word(op_rd, phy_addr, reg_addr, wr_data);
        r_op_rd   <= op_rd;
        r_bit_cnt <= '0;
        r_ta_err  <= 1'b0;
      end else if (w_busy) begin
        if (w_rise) begin
          if (r_bit_cnt == 6'(MDIO_TA_BIT)) r_ta_err <= mdio_i;
          if (r_bit_cnt > 6'(MDIO_TA_BIT))  r_rx_sr  <= {r_rx_sr[14:0], mdio_i};
        end
        if (w_fall) begin
          if (!w_last_bit)        r_bit_cnt <= r_bit_cnt + 6'd1;
          if (r_state != ST_PRE) r_tx_sr   <= {r_tx_sr[30:0], 1'b0};
          if (w_last_bit) begin
            r_rd_err <= r_op_rd ? r_ta_err : 1'b0;
            if (r_op_rd) r_rd_data <= r_rx_sr;
          end
        end
      end
    end
  end

  assign busy    = w_busy;
  assign done    = r_done;
  assign rd_data = r_rd_data;
  assign rd_err  = r_rd_err;
  assign mdio_oe = w_oe;
  assign mdio_o  = w_oe ? w_tx_bit : 1'b1;

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master: CLK_DIV=25 instance for frame content, CLK_DIV=2 for back-to-back.
module tb_mdio_master;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst_n   [2];
  logic        start_s [2];
  logic        op_rd_s [2];
  logic [4:0]  pa_s    [2];
  logic [4:0]  ra_s    [2];
  logic [15:0] wd_s    [2];
  logic        busy_s  [2];
  logic        done_s  [2];
  logic [15:0] rdd_s   [2];
  logic        rde_s   [2];
  logic        mdc_s   [2];
  logic        mdo_s   [2];
  logic        oe_s    [2];
  logic        mdi_s   [2];
  logic        phy_drv [2];
  logic [15:0] exp_rd  [2];

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  // Pin model: master drives when enabled, otherwise the PHY (or pull-up) does
  assign mdi_s[0] = oe_s[0] ? mdo_s[0] : phy_drv[0];
  assign mdi_s[1] = oe_s[1] ? mdo_s[1] : phy_drv[1];

  mdio_master #(.CLK_DIV(25)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n[0]), .start(start_s[0]), .op_rd(op_rd_s[0]),
    .phy_addr(pa_s[0]), .reg_addr(ra_s[0]), .wr_data(wd_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .rd_data(rdd_s[0]), .rd_err(rde_s[0]),
    .mdc(mdc_s[0]), .mdio_o(mdo_s[0]), .mdio_oe(oe_s[0]), .mdio_i(mdi_s[0])
  );

  mdio_master #(.CLK_DIV(2)) dut2 (
    .sys_clk(clk), .sys_rst_n(rst_n[1]), .start(start_s[1]), .op_rd(op_rd_s[1]),
    .phy_addr(pa_s[1]), .reg_addr(ra_s[1]), .wr_data(wd_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .rd_data(rdd_s[1]), .rd_err(rde_s[1]),
    .mdc(mdc_s[1]), .mdio_o(mdo_s[1]), .mdio_oe(oe_s[1]), .mdio_i(mdi_s[1])
  );

  task automatic chk(input string tag, input string what, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s.%s: observed %h expected %h", tag, what, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input int unsigned idx, input string tag);
    chk(tag, "reset_outputs",
        64'({busy_s[idx], done_s[idx], oe_s[idx], mdo_s[idx], mdc_s[idx], rde_s[idx], rdd_s[idx]}),
        64'({1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000}));
  endtask

  task automatic run_frame(input int unsigned idx, input string tag, input logic rd,
                           input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] wd,
                           input logic phy_on, input logic [15:0] pv,
                           input int unsigned poke_cyc, input int unsigned abort_bit);
    int unsigned div, cyc, rises, falls, rise1, rise2, limit, dn;
    logic [63:0] got_bits, got_oe, exp_bits, exp_oe;
    logic        prev_mdc, seen_done, aborted, exp_err;
    div      = (idx == 0) ? 25 : 2;
    limit    = 1 + 128 * div + 20;
    exp_bits = rd ? {32'hFFFF_FFFF, 2'b01, 2'b10, pa, ra, 18'h3FFFF}
                  : {32'hFFFF_FFFF, 2'b01, 2'b01, pa, ra, 2'b10, wd};
    exp_oe   = rd ? {{46{1'b1}}, 18'h00000} : {64{1'b1}};
    got_bits = '0; got_oe = '0;
    rises = 0; falls = 0; rise1 = 0; rise2 = 0; dn = 0;
    seen_done = 1'b0; aborted = 1'b0;
    phy_drv[idx] = 1'b1;

    @(negedge clk);
    start_s[idx] = 1'b1; op_rd_s[idx] = rd; pa_s[idx] = pa; ra_s[idx] = ra; wd_s[idx] = wd;
    @(negedge clk);
    start_s[idx] = 1'b0;
    cyc = 1;
    chk(tag, "first_cycle", 64'({busy_s[idx], oe_s[idx], mdo_s[idx], mdc_s[idx]}), 64'h E);
    prev_mdc = mdc_s[idx];

    while (!seen_done && !aborted && cyc < limit) begin
      @(negedge clk);
      cyc++;
      start_s[idx] = 1'b0;
      if (cyc == poke_cyc) begin
        start_s[idx] = 1'b1; op_rd_s[idx] = ~rd; pa_s[idx] = ~pa; ra_s[idx] = ~ra; wd_s[idx] = ~wd;
      end
      if (mdc_s[idx] && !prev_mdc) begin
        if (rises < 64) begin
          got_bits[6'(63 - rises)] = mdo_s[idx];
          got_oe[6'(63 - rises)]   = oe_s[idx];
        end
        if (rises == 0) rise1 = cyc;
        if (rises == 1) rise2 = cyc;
        rises++;
      end
      if (!mdc_s[idx] && prev_mdc) begin
        falls++;
        if (!phy_on)                      phy_drv[idx] = 1'b1;
        else if (falls == 47)             phy_drv[idx] = 1'b0;
        else if (falls >= 48 && falls <= 63) phy_drv[idx] = pv[4'(63 - falls)];
        else                              phy_drv[idx] = 1'b1;
        if (falls == abort_bit) begin
          rst_n[idx] = 1'b0;
          @(negedge clk);
          rst_n[idx] = 1'b1;
          chk_reset_vals(idx, tag);
          aborted = 1'b1;
        end
      end
      if (done_s[idx]) seen_done = 1'b1;
      prev_mdc = mdc_s[idx];
    end

    if (aborted) begin
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (done_s[idx]) dn++;
      end
      chk(tag, "no_done_after_reset", 64'(dn), 64'd0);
      exp_rd[idx] = 16'h0000;
    end else begin
      chk(tag, "done_seen", 64'(seen_done), 64'd1);
      chk(tag, "done_latency", 64'(cyc), 64'(1 + 128 * div));
      chk(tag, "done_state", 64'({busy_s[idx], oe_s[idx], mdo_s[idx], mdc_s[idx]}), 64'h2);
      chk(tag, "bits", got_bits, exp_bits);
      chk(tag, "oe", got_oe, exp_oe);
      chk(tag, "rise_count", 64'(rises), 64'd64);
      chk(tag, "first_rise", 64'(rise1), 64'(1 + div));
      chk(tag, "mdc_period", 64'(rise2 - rise1), 64'(2 * div));
      if (rd) exp_rd[idx] = phy_on ? pv : 16'hFFFF;
      exp_err = rd && !phy_on;
      chk(tag, "rd_data", 64'(rdd_s[idx]), 64'(exp_rd[idx]));
      chk(tag, "rd_err", 64'(rde_s[idx]), 64'(exp_err));
    end
    phy_drv[idx] = 1'b1;
  endtask

  initial begin
    int unsigned extra;
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; start_s[i] = 1'b0; op_rd_s[i] = 1'b0;
      pa_s[i] = '0; ra_s[i] = '0; wd_s[i] = '0; phy_drv[i] = 1'b1; exp_rd[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk_reset_vals(0, "rst0");
    chk_reset_vals(1, "rst1");
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(negedge clk);
    chk_reset_vals(0, "post_rst0");

    run_frame(0, "wr",       1'b0, 5'h01, 5'h00, 16'h1140, 1'b0, 16'h0000, 0, 99);
    run_frame(0, "rd",       1'b1, 5'h01, 5'h02, 16'h0000, 1'b1, 16'h0141, 0, 99);
    run_frame(0, "rd_abs",   1'b1, 5'h01, 5'h02, 16'h0000, 1'b0, 16'h0000, 0, 99);
    run_frame(0, "wr_poke",  1'b0, 5'h03, 5'h04, 16'hA5C3, 1'b0, 16'h0000, 500, 99);

    extra = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done_s[0] || busy_s[0]) extra++;
    end
    chk("wr_poke", "no_second_frame", 64'(extra), 64'd0);

    run_frame(0, "rd_abort", 1'b1, 5'h01, 5'h02, 16'h0000, 1'b1, 16'h0141, 0, 40);
    run_frame(0, "rd_after", 1'b1, 5'h1F, 5'h1F, 16'h0000, 1'b1, 16'hBEEF, 0, 99);

    run_frame(1, "d2_wr",    1'b0, 5'h0A, 5'h15, 16'h5A0F, 1'b0, 16'h0000, 0, 99);
    run_frame(1, "d2_rd",    1'b1, 5'h0A, 5'h15, 16'h0000, 1'b1, 16'hC33C, 0, 99);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
